// File: rtl/ddr3_ccc_phase_ctrl.sv
// DDR3 clock-conditioning PLL sequencer: owns the power-down / lock-wait
// start-up sequence and turns phase-shift requests from PHY training into
// spaced PHASE_ROTATE pulses, with an optional LOAD_PHASE_N strobe.
module ddr3_ccc_phase_ctrl #(
  parameter int ROTATE_HIGH = 2,
  parameter int ROTATE_GAP  = 4,
  parameter int STEP_W      = 8,
  parameter int PD_CYCLES   = 16,
  parameter int LOCK_WAIT   = 1024
) (
  input  logic              CLK,
  input  logic              ARST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [STEP_W-1:0] REQ_STEPS,
  input  logic              REQ_DIR,
  input  logic [2:0]        REQ_SEL,
  input  logic              REQ_LOAD,
  input  logic              RESTART,
  input  logic              PLL_LOCK,
  output logic              PHASE_OUT0_SEL,
  output logic              PHASE_OUT2_SEL,
  output logic              PHASE_OUT3_SEL,
  output logic              PHASE_DIRECTION,
  output logic              PHASE_ROTATE,
  output logic              LOAD_PHASE_N,
  output logic              PLL_POWERDOWN_N,
  output logic              BUSY,
  output logic              LOCKED,
  output logic              DONE,
  output logic              ERR,
  output logic              LOCK_TIMEOUT,
  output logic [STEP_W-1:0] STEPS_DONE
);

  // One shared timer serves power-down hold, lock wait and rotate high/low.
  localparam int TMR_W = $clog2(PD_CYCLES + LOCK_WAIT + ROTATE_HIGH + ROTATE_GAP) + 1;
  localparam logic [TMR_W-1:0] PD_LAST   = TMR_W'(PD_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_WAIT - 1);
  localparam logic [TMR_W-1:0] HI_LAST   = TMR_W'(ROTATE_HIGH - 1);
  localparam logic [TMR_W-1:0] LO_LAST   = TMR_W'(ROTATE_GAP - 1);

  typedef enum logic [2:0] {
    ST_PD,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_SETUP,
    ST_ROT_HI,
    ST_ROT_LO,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic               lock_sync_p0;
  logic               lock_sync_p1;
  logic               accept;
  logic               in_request;
  logic [STEP_W-1:0]  req_steps_q;
  logic [2:0]         req_sel_q;
  logic               req_load_q;

  assign REQ_READY  = (state == ST_IDLE) && !RESTART;
  assign accept     = REQ_READY && lock_sync_p1 && REQ_VALID;
  assign in_request = (state == ST_SETUP) || (state == ST_ROT_HI) ||
                      (state == ST_ROT_LO) || (state == ST_LOAD);

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      lock_sync_p0 <= 1'b0;
      lock_sync_p1 <= 1'b0;
    end else begin
      lock_sync_p0 <= PLL_LOCK;
      lock_sync_p1 <= lock_sync_p0;
    end
  end

  // Request fields are captured on acceptance and held for the whole request
  always_ff @(posedge CLK) begin
    if (accept) begin
      req_steps_q <= REQ_STEPS;
      req_sel_q   <= REQ_SEL;
      req_load_q  <= REQ_LOAD;
    end
  end

  // Sequencer: start-up, lock supervision and rotate-pulse generation
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state           <= ST_PD;
      timer           <= '0;
      PLL_POWERDOWN_N <= 1'b0;
      PHASE_OUT0_SEL  <= 1'b0;
      PHASE_OUT2_SEL  <= 1'b0;
      PHASE_OUT3_SEL  <= 1'b0;
      PHASE_DIRECTION <= 1'b0;
      PHASE_ROTATE    <= 1'b0;
      LOAD_PHASE_N    <= 1'b1;
      BUSY            <= 1'b1;
      LOCKED          <= 1'b0;
      DONE            <= 1'b0;
      ERR             <= 1'b0;
      LOCK_TIMEOUT    <= 1'b0;
      STEPS_DONE      <= '0;
    end else begin
      DONE         <= 1'b0;
      ERR          <= 1'b0;
      LOCK_TIMEOUT <= 1'b0;
      LOCKED       <= lock_sync_p1 && PLL_POWERDOWN_N;

      if (in_request && !lock_sync_p1) begin
        // Lock lost mid-request: drop everything to the PLL and relock
        state           <= ST_WAIT_LOCK;
        timer           <= '0;
        ERR             <= 1'b1;
        PHASE_ROTATE    <= 1'b0;
        PHASE_OUT0_SEL  <= 1'b0;
        PHASE_OUT2_SEL  <= 1'b0;
        PHASE_OUT3_SEL  <= 1'b0;
        PHASE_DIRECTION <= 1'b0;
        LOAD_PHASE_N    <= 1'b1;
      end else begin
        case (state)
          ST_PD: begin
            if (timer == PD_LAST) begin
              state           <= ST_WAIT_LOCK;
              PLL_POWERDOWN_N <= 1'b1;
              timer           <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          ST_WAIT_LOCK: begin
            if (RESTART) begin
              state           <= ST_PD;
              PLL_POWERDOWN_N <= 1'b0;
              timer           <= '0;
            end else if (lock_sync_p1) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end else if (timer == LOCK_LAST) begin
              // Retry forever: another power-down cycle, then wait again
              LOCK_TIMEOUT    <= 1'b1;
              state           <= ST_PD;
              PLL_POWERDOWN_N <= 1'b0;
              timer           <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          ST_IDLE: begin
            if (RESTART) begin
              state           <= ST_PD;
              PLL_POWERDOWN_N <= 1'b0;
              timer           <= '0;
              BUSY            <= 1'b1;
            end else if (!lock_sync_p1) begin
              ERR   <= 1'b1;
              state <= ST_WAIT_LOCK;
              timer <= '0;
              BUSY  <= 1'b1;
            end else if (REQ_VALID) begin
              // Selects and direction settle a full cycle before any rotate
              state           <= ST_SETUP;
              BUSY            <= 1'b1;
              STEPS_DONE      <= '0;
              PHASE_OUT0_SEL  <= REQ_SEL[0];
              PHASE_OUT2_SEL  <= REQ_SEL[1];
              PHASE_OUT3_SEL  <= REQ_SEL[2];
              PHASE_DIRECTION <= REQ_DIR;
            end
          end

          ST_SETUP: begin
            if ((req_steps_q == '0) || (req_sel_q == 3'b000)) begin
              if (req_load_q) begin
                state        <= ST_LOAD;
                LOAD_PHASE_N <= 1'b0;
              end else begin
                state           <= ST_DONE;
                DONE            <= 1'b1;
                PHASE_OUT0_SEL  <= 1'b0;
                PHASE_OUT2_SEL  <= 1'b0;
                PHASE_OUT3_SEL  <= 1'b0;
                PHASE_DIRECTION <= 1'b0;
              end
            end else begin
              state        <= ST_ROT_HI;
              PHASE_ROTATE <= 1'b1;
              STEPS_DONE   <= STEPS_DONE + 1'b1;
              timer        <= '0;
            end
          end

          ST_ROT_HI: begin
            if (timer == HI_LAST) begin
              state        <= ST_ROT_LO;
              PHASE_ROTATE <= 1'b0;
              timer        <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end

          ST_ROT_LO: begin
            if (timer == LO_LAST) begin
              timer <= '0;
              if (STEPS_DONE != req_steps_q) begin
                state        <= ST_ROT_HI;
                PHASE_ROTATE <= 1'b1;
                STEPS_DONE   <= STEPS_DONE + 1'b1;
              end else if (req_load_q) begin
                state        <= ST_LOAD;
                LOAD_PHASE_N <= 1'b0;
              end else begin
                state           <= ST_DONE;
                DONE            <= 1'b1;
                PHASE_OUT0_SEL  <= 1'b0;
                PHASE_OUT2_SEL  <= 1'b0;
                PHASE_OUT3_SEL  <= 1'b0;
                PHASE_DIRECTION <= 1'b0;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end

          ST_LOAD: begin
            state           <= ST_DONE;
            LOAD_PHASE_N    <= 1'b1;
            DONE            <= 1'b1;
            PHASE_OUT0_SEL  <= 1'b0;
            PHASE_OUT2_SEL  <= 1'b0;
            PHASE_OUT3_SEL  <= 1'b0;
            PHASE_DIRECTION <= 1'b0;
          end

          ST_DONE: begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end

          default: begin
            state           <= ST_PD;
            PLL_POWERDOWN_N <= 1'b0;
            timer           <= '0;
            BUSY            <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_ccc_phase_ctrl.sv
// Directed bench for ddr3_ccc_phase_ctrl: start-up, lock timeout, rotate
// requests, zero-step requests, lock loss, restart priority, async reset.
module tb_ddr3_ccc_phase_ctrl;

  logic       CLK;
  logic       ARST;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [7:0] REQ_STEPS;
  logic       REQ_DIR;
  logic [2:0] REQ_SEL;
  logic       REQ_LOAD;
  logic       RESTART;
  logic       PLL_LOCK;
  logic       PHASE_OUT0_SEL;
  logic       PHASE_OUT2_SEL;
  logic       PHASE_OUT3_SEL;
  logic       PHASE_DIRECTION;
  logic       PHASE_ROTATE;
  logic       LOAD_PHASE_N;
  logic       PLL_POWERDOWN_N;
  logic       BUSY;
  logic       LOCKED;
  logic       DONE;
  logic       ERR;
  logic       LOCK_TIMEOUT;
  logic [7:0] STEPS_DONE;

  int n_assert = 0;
  int n_fail   = 0;

  ddr3_ccc_phase_ctrl #(
    .ROTATE_HIGH(2),
    .ROTATE_GAP (4),
    .STEP_W     (8),
    .PD_CYCLES  (16),
    .LOCK_WAIT  (64)
  ) dut (
    .CLK            (CLK),
    .ARST           (ARST),
    .REQ_VALID      (REQ_VALID),
    .REQ_READY      (REQ_READY),
    .REQ_STEPS      (REQ_STEPS),
    .REQ_DIR        (REQ_DIR),
    .REQ_SEL        (REQ_SEL),
    .REQ_LOAD       (REQ_LOAD),
    .RESTART        (RESTART),
    .PLL_LOCK       (PLL_LOCK),
    .PHASE_OUT0_SEL (PHASE_OUT0_SEL),
    .PHASE_OUT2_SEL (PHASE_OUT2_SEL),
    .PHASE_OUT3_SEL (PHASE_OUT3_SEL),
    .PHASE_DIRECTION(PHASE_DIRECTION),
    .PHASE_ROTATE   (PHASE_ROTATE),
    .LOAD_PHASE_N   (LOAD_PHASE_N),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
    .BUSY           (BUSY),
    .LOCKED         (LOCKED),
    .DONE           (DONE),
    .ERR            (ERR),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STEPS_DONE     (STEPS_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n active edges and settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Present a request in the current (IDLE) cycle; returns in the SETUP cycle
  task automatic issue(input logic [7:0] steps, input logic dir,
                       input logic [2:0] sel, input logic ld);
    REQ_STEPS = steps;
    REQ_DIR   = dir;
    REQ_SEL   = sel;
    REQ_LOAD  = ld;
    REQ_VALID = 1'b1;
    tick(1);
    REQ_VALID = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_rot;
    logic [7:0] exp_steps;

    ARST = 1'b1; REQ_VALID = 1'b0; REQ_STEPS = 8'd0; REQ_DIR = 1'b0;
    REQ_SEL = 3'b000; REQ_LOAD = 1'b0; RESTART = 1'b0; PLL_LOCK = 1'b0;

    // ---- reset values ----
    tick(1);
    chk1("rst_pd_n", PLL_POWERDOWN_N, 1'b0);
    chk1("rst_load_n", LOAD_PHASE_N, 1'b1);
    chk1("rst_rotate", PHASE_ROTATE, 1'b0);
    chk1("rst_sel0", PHASE_OUT0_SEL, 1'b0);
    chk1("rst_busy", BUSY, 1'b1);
    chk1("rst_locked", LOCKED, 1'b0);
    chk1("rst_done", DONE, 1'b0);
    chk1("rst_err", ERR, 1'b0);
    chk1("rst_tmo", LOCK_TIMEOUT, 1'b0);
    chk8("rst_steps", STEPS_DONE, 8'd0);
    chk1("rst_ready", REQ_READY, 1'b0);
    ARST = 1'b0;

    // ---- lock timeout with PLL_LOCK held low ----
    tick(15);
    chk1("tmo_pd_n_15", PLL_POWERDOWN_N, 1'b0);
    tick(1);
    chk1("tmo_pd_n_16", PLL_POWERDOWN_N, 1'b1);
    tick(63);
    chk1("tmo_pulse_79", LOCK_TIMEOUT, 1'b0);
    chk1("tmo_pd_n_79", PLL_POWERDOWN_N, 1'b1);
    tick(1);
    chk1("tmo_pulse_80", LOCK_TIMEOUT, 1'b1);
    chk1("tmo_pd_n_80", PLL_POWERDOWN_N, 1'b0);
    chk1("tmo_locked_80", LOCKED, 1'b0);
    tick(1);
    chk1("tmo_pulse_81", LOCK_TIMEOUT, 1'b0);
    tick(14);
    chk1("tmo_pd_n_95", PLL_POWERDOWN_N, 1'b0);
    tick(1);
    chk1("tmo_pd_n_96", PLL_POWERDOWN_N, 1'b1);
    chk1("tmo_busy", BUSY, 1'b1);

    // ---- start-up with lock present ----
    PLL_LOCK = 1'b1;
    ARST = 1'b1;
    #1;
    chk1("arst_pd_n", PLL_POWERDOWN_N, 1'b0);
    chk1("arst_busy", BUSY, 1'b1);
    tick(1);
    ARST = 1'b0;
    tick(15);
    chk1("su_pd_n_15", PLL_POWERDOWN_N, 1'b0);
    tick(1);
    chk1("su_pd_n_16", PLL_POWERDOWN_N, 1'b1);
    chk1("su_ready_16", REQ_READY, 1'b0);
    tick(1);
    chk1("su_locked", LOCKED, 1'b1);
    chk1("su_ready", REQ_READY, 1'b1);
    chk1("su_busy", BUSY, 1'b0);

    // ---- 3 steps, dir 1, sel 101, load ----
    issue(8'd3, 1'b1, 3'b101, 1'b1);
    chk1("r3_sel0_k1", PHASE_OUT0_SEL, 1'b1);
    chk1("r3_sel2_k1", PHASE_OUT2_SEL, 1'b0);
    chk1("r3_sel3_k1", PHASE_OUT3_SEL, 1'b1);
    chk1("r3_dir_k1", PHASE_DIRECTION, 1'b1);
    chk1("r3_rot_k1", PHASE_ROTATE, 1'b0);
    chk1("r3_ready_k1", REQ_READY, 1'b0);
    chk8("r3_steps_k1", STEPS_DONE, 8'd0);
    for (int d = 2; d <= 21; d++) begin
      tick(1);
      exp_rot = (d == 2) || (d == 3) || (d == 8) || (d == 9) || (d == 14) || (d == 15);
      exp_steps = (d >= 14) ? 8'd3 : ((d >= 8) ? 8'd2 : 8'd1);
      chk1("r3_rot", PHASE_ROTATE, exp_rot);
      chk1("r3_load_n", LOAD_PHASE_N, d != 20);
      chk1("r3_done", DONE, d == 21);
      chk1("r3_sel0", PHASE_OUT0_SEL, d <= 20);
      chk1("r3_sel3", PHASE_OUT3_SEL, d <= 20);
      chk1("r3_dir", PHASE_DIRECTION, d <= 20);
      chk8("r3_steps", STEPS_DONE, exp_steps);
    end
    tick(1);
    chk1("r3_ready_after", REQ_READY, 1'b1);
    chk1("r3_busy_after", BUSY, 1'b0);
    chk1("r3_sel0_after", PHASE_OUT0_SEL, 1'b0);
    chk8("r3_steps_after", STEPS_DONE, 8'd3);

    // ---- zero steps, no load: DONE at k+2 ----
    issue(8'd0, 1'b1, 3'b111, 1'b0);
    chk1("z0_rot_k1", PHASE_ROTATE, 1'b0);
    chk8("z0_steps_k1", STEPS_DONE, 8'd0);
    tick(1);
    chk1("z0_done_k2", DONE, 1'b1);
    chk1("z0_rot_k2", PHASE_ROTATE, 1'b0);
    chk1("z0_load_n_k2", LOAD_PHASE_N, 1'b1);
    tick(1);
    chk1("z0_done_k3", DONE, 1'b0);
    chk1("z0_ready_k3", REQ_READY, 1'b1);

    // ---- SEL=0, 5 steps, load: LOAD at k+2, DONE at k+3, no pulses ----
    issue(8'd5, 1'b0, 3'b000, 1'b1);
    tick(1);
    chk1("s0_load_n_k2", LOAD_PHASE_N, 1'b0);
    chk1("s0_rot_k2", PHASE_ROTATE, 1'b0);
    chk1("s0_done_k2", DONE, 1'b0);
    tick(1);
    chk1("s0_done_k3", DONE, 1'b1);
    chk1("s0_load_n_k3", LOAD_PHASE_N, 1'b1);
    chk8("s0_steps_k3", STEPS_DONE, 8'd0);
    tick(1);
    chk1("s0_ready", REQ_READY, 1'b1);

    // ---- lock lost during second ROT_LO of a 5-step request ----
    issue(8'd5, 1'b0, 3'b111, 1'b0);
    tick(8);
    chk1("ll_rot_k9", PHASE_ROTATE, 1'b1);
    chk8("ll_steps_k9", STEPS_DONE, 8'd2);
    tick(1);
    chk1("ll_rot_k10", PHASE_ROTATE, 1'b0);
    PLL_LOCK = 1'b0;
    tick(2);
    chk1("ll_err_k12", ERR, 1'b0);
    chk1("ll_sel0_k12", PHASE_OUT0_SEL, 1'b1);
    tick(1);
    chk1("ll_err_k13", ERR, 1'b1);
    chk1("ll_rot_k13", PHASE_ROTATE, 1'b0);
    chk1("ll_sel0_k13", PHASE_OUT0_SEL, 1'b0);
    chk1("ll_sel3_k13", PHASE_OUT3_SEL, 1'b0);
    chk1("ll_done_k13", DONE, 1'b0);
    chk1("ll_locked_k13", LOCKED, 1'b0);
    chk1("ll_busy_k13", BUSY, 1'b1);
    chk8("ll_steps_k13", STEPS_DONE, 8'd2);
    tick(1);
    chk1("ll_err_k14", ERR, 1'b0);
    chk1("ll_done_k14", DONE, 1'b0);
    chk1("ll_ready_k14", REQ_READY, 1'b0);
    PLL_LOCK = 1'b1;
    tick(2);
    chk1("ll_ready_k16", REQ_READY, 1'b0);
    tick(1);
    chk1("ll_ready_k17", REQ_READY, 1'b1);
    chk1("ll_locked_k17", LOCKED, 1'b1);
    chk8("ll_steps_k17", STEPS_DONE, 8'd2);

    // ---- RESTART and REQ_VALID in the same IDLE cycle ----
    REQ_STEPS = 8'd1; REQ_SEL = 3'b111; REQ_DIR = 1'b1; REQ_LOAD = 1'b0;
    REQ_VALID = 1'b1; RESTART = 1'b1;
    #1;
    chk1("rs_ready", REQ_READY, 1'b0);
    tick(1);
    REQ_VALID = 1'b0; RESTART = 1'b0;
    chk1("rs_pd_n", PLL_POWERDOWN_N, 1'b0);
    chk1("rs_sel0", PHASE_OUT0_SEL, 1'b0);
    chk1("rs_busy", BUSY, 1'b1);
    chk8("rs_steps", STEPS_DONE, 8'd2);
    tick(15);
    chk1("rs_pd_n_15", PLL_POWERDOWN_N, 1'b0);
    tick(1);
    chk1("rs_pd_n_16", PLL_POWERDOWN_N, 1'b1);
    tick(1);
    chk1("rs_ready_17", REQ_READY, 1'b1);

    // ---- ARST mid ROT_HI ----
    issue(8'd3, 1'b1, 3'b001, 1'b0);
    tick(1);
    chk1("ar_rot_k2", PHASE_ROTATE, 1'b1);
    chk1("ar_sel0_k2", PHASE_OUT0_SEL, 1'b1);
    ARST = 1'b1;
    #1;
    chk1("ar_rot", PHASE_ROTATE, 1'b0);
    chk1("ar_pd_n", PLL_POWERDOWN_N, 1'b0);
    chk1("ar_sel0", PHASE_OUT0_SEL, 1'b0);
    chk1("ar_dir", PHASE_DIRECTION, 1'b0);
    chk1("ar_busy", BUSY, 1'b1);
    chk1("ar_locked", LOCKED, 1'b0);
    chk8("ar_steps", STEPS_DONE, 8'd0);
    tick(2);
    ARST = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_ccc_phase_ctrl.md
# ddr3_ccc_phase_ctrl

Sequencing controller that drives the dynamic-phase and power-down inputs of the DDR3 clock-conditioning PLL and watches its lock output. It sits in the DDR3 fabric clock domain, between the PHY training logic (requester) and the PLL phase-adjust port. It owns the PLL start-up sequence: power-down hold, then lock wait with timeout and retry. It executes phase-shift requests by issuing N spaced PHASE_ROTATE pulses on a selected set of outputs, optionally followed by a LOAD_PHASE_N strobe.

## Interface
- ROTATE_HIGH, 2: cycles PHASE_ROTATE is held high per step (≥1)
- ROTATE_GAP, 4: cycles PHASE_ROTATE is held low after each step (≥1)
- STEP_W, 8: width of step count
- PD_CYCLES, 16: cycles PLL_POWERDOWN_N is held low (≥1)
- LOCK_WAIT, 1024: lock timeout in cycles (≥4)

- CLK  in  1  controller clock
- ARST  in  1  asynchronous reset, active-high
- REQ_VALID  in  1  phase request valid
- REQ_READY  out  1  request accept; combinational = (state==IDLE) & ~RESTART
- REQ_STEPS  in  STEP_W  number of rotate steps
- REQ_DIR  in  1  direction, driven onto PHASE_DIRECTION
- REQ_SEL  in  3  {OUT3, OUT2, OUT0} output select
- REQ_LOAD  in  1  issue LOAD_PHASE_N after the steps
- RESTART  in  1  force PLL power-down/relock
- PLL_LOCK  in  1  PLL lock, asynchronous; 2-FF synchronized internally
- PHASE_OUT0_SEL, PHASE_OUT2_SEL, PHASE_OUT3_SEL  out  1 each  to PLL
- PHASE_DIRECTION  out  1  to PLL
- PHASE_ROTATE  out  1  to PLL
- LOAD_PHASE_N  out  1  to PLL, active-low
- PLL_POWERDOWN_N  out  1  to PLL, active-low
- BUSY  out  1  high in every state except IDLE
- LOCKED  out  1  synchronized lock, qualified by PLL_POWERDOWN_N
- DONE  out  1  one-cycle pulse at request completion
- ERR  out  1  one-cycle pulse when lock is lost during IDLE or a request
- LOCK_TIMEOUT  out  1  one-cycle pulse on lock-wait expiry
- STEPS_DONE  out  STEP_W  rotate pulses issued in the current/last request

## Operation
- All outputs are registered except REQ_READY.
- States: PD, WAIT_LOCK, IDLE, SETUP, ROT_HI, ROT_LO, LOAD, DONE.
- Reset values:
  - state PD, PLL_POWERDOWN_N=0, all PHASE_* = 0, LOAD_PHASE_N=1.
  - BUSY=1, LOCKED=0, DONE=0, ERR=0, LOCK_TIMEOUT=0, STEPS_DONE=0, sync FFs=0.
- PD: hold PLL_POWERDOWN_N=0 for PD_CYCLES cycles, then go to WAIT_LOCK with PLL_POWERDOWN_N=1 and the timer cleared.
- WAIT_LOCK:
  - Synced lock=1 → IDLE.
  - Timer reaches LOCK_WAIT−1 → LOCK_TIMEOUT pulse, go to PD (retries indefinitely).
  - RESTART → PD.
- IDLE:
  - RESTART → PD. RESTART takes priority over REQ_VALID in the same cycle, because REQ_READY is low.
  - Synced lock=0 → ERR pulse, go to WAIT_LOCK.
  - REQ_VALID & REQ_READY → capture all REQ_* fields, clear STEPS_DONE, go to SETUP.
- SETUP (1 cycle):
  - Drive the selects from REQ_SEL and PHASE_DIRECTION from REQ_DIR.
  - If REQ_STEPS==0 or REQ_SEL==0: no pulses; go to LOAD if REQ_LOAD, else DONE.
  - Otherwise go to ROT_HI.
- ROT_HI: PHASE_ROTATE=1 for ROTATE_HIGH cycles; STEPS_DONE increments on entry.
- ROT_LO: PHASE_ROTATE=0 for ROTATE_GAP cycles. Then:
  - steps remain → ROT_HI
  - no steps remain, REQ_LOAD set → LOAD
  - no steps remain, REQ_LOAD clear → DONE
- Selects and direction stay stable from SETUP through LOAD; they never change while PHASE_ROTATE=1.
- LOAD: LOAD_PHASE_N=0 for 1 cycle, then DONE.
- DONE: DONE=1 for 1 cycle; selects and direction return to 0; go to IDLE.
- Lock loss in SETUP/ROT_HI/ROT_LO/LOAD:
  - Abort the request; ERR pulse.
  - PHASE_ROTATE, selects and direction go to 0 and LOAD_PHASE_N to 1 on the next edge.
  - Go to WAIT_LOCK. No DONE pulse. STEPS_DONE holds the partial count.
- RESTART outside IDLE/WAIT_LOCK is ignored.
- ARST asserted at any point, including mid-rotate, returns all outputs to their reset values immediately.

## Timing
- Lock-sync latency: 2 cycles from PLL_LOCK to the internal synced lock.
- Start-up: PLL_POWERDOWN_N rises PD_CYCLES cycles after ARST deassertion. IDLE is entered 1 cycle after the synced lock is seen.
- Request accepted at edge k:
  - SETUP at k+1.
  - First PHASE_ROTATE high at k+2.
  - Pulse i (0-based) is high during k+2+i·(H+G) … k+1+i·(H+G)+H, where H=ROTATE_HIGH and G=ROTATE_GAP.
  - LOAD at k+2+N·(H+G).
  - DONE one cycle after LOAD. Without LOAD, DONE is at k+2+N·(H+G).
- Zero-step request: DONE at k+2, or LOAD at k+2 and DONE at k+3.
- REQ_READY re-asserts the cycle after DONE.
- STEPS_DONE wraps modulo 2^STEP_W; it never exceeds REQ_STEPS.

## Test plan
- Start-up (PD_CYCLES=16): release ARST, PLL_LOCK=1 from t=0 → PLL_POWERDOWN_N rises after 16 cycles; LOCKED and REQ_READY high within 3 cycles after that; BUSY falls.
- Lock timeout (LOCK_WAIT=64): hold PLL_LOCK=0 → LOCK_TIMEOUT pulse 64 cycles after power-up release, PD re-entered, PLL_POWERDOWN_N low 16 cycles, repeated.
- Request STEPS=3, DIR=1, SEL=3'b101, LOAD=1 accepted at k (H=2, G=4):
  - PHASE_OUT0_SEL=PHASE_OUT3_SEL=1 and PHASE_DIRECTION=1 from k+1; PHASE_OUT2_SEL=0.
  - Rotate high k+2–3, k+8–9, k+14–15.
  - LOAD_PHASE_N low at k+20, DONE at k+21, STEPS_DONE=3.
- STEPS=0, LOAD=0 → no PHASE_ROTATE, DONE at k+2. SEL=0 with STEPS=5 → no pulses, STEPS_DONE=0.
- Drop PLL_LOCK during the second ROT_LO of a 5-step request → ERR pulse, PHASE_ROTATE/selects 0, no DONE, STEPS_DONE=2, WAIT_LOCK; relock returns to IDLE.
- RESTART and REQ_VALID high in the same IDLE cycle → request not accepted, PD entered; ARST asserted mid-ROT_HI → PHASE_ROTATE=0 and PLL_POWERDOWN_N=0 immediately.
